// File: rtl/lsu_pkg.sv
// Shared encodings and defaults for the load/store unit and its lane aligner.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned DEF_DATA_BASE  = 1024;
    localparam int unsigned DEF_DATA_BYTES = 256;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RMW_RD,
        RMW_WR,
        WRITE,
        RESP
    } lsu_state_t;

    // Access footprint in bytes; the reserved encoding is rejected as misaligned elsewhere.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational little-endian lane handling: sub-word store merge and load extract/extend.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    output logic [31:0] merged,
    output logic [31:0] rdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        merged = word;
        rdata  = word;
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: begin
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
                rdata = {{24{sign_ext & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
                rdata = {{16{sign_ext & half_v[15]}}, half_v};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: word/sub-word loads and stores via a small access FSM.
// Define LSU_RANGE_CHECK_EN to reject requests outside [DATA_BASE, DATA_BASE+DATA_BYTES).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_BASE  = DEF_DATA_BASE,
    parameter int unsigned DATA_BYTES = DEF_DATA_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] memAdr,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] writeData,
    input  logic [31:0] readData
);

    lsu_state_t  state;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [31:0] wdata_q;
    logic [31:0] merged;
    logic [31:0] rdata;
    logic        misaligned;
    logic        range_bad;
    logic        req_err;
    logic [32:0] end_addr;

    assign misaligned = (req_size == 2'b11)
                      | ((req_size == SZ_HALF) & req_addr[0])
                      | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));

    assign end_addr  = {1'b0, req_addr} + {30'd0, size_bytes(req_size)};
    assign range_bad = (req_addr < DATA_BASE)
                     | (end_addr > (33'(DATA_BASE) + 33'(DATA_BYTES)));

`ifdef LSU_RANGE_CHECK_EN
    assign req_err = misaligned | range_bad;
`else
    logic unused_range;
    assign unused_range = range_bad;
    assign req_err = misaligned;
`endif

    lsu_lane_align u_align (
        .word     (readData),
        .wdata    (wdata_q),
        .size     (size_q),
        .lane     (lane_q),
        .sign_ext (sign_q),
        .merged   (merged),
        .rdata    (rdata)
    );

    // Handshake and strobes are pure decodes of the state register.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign memRead    = (state == READ)   | (state == RMW_RD);
    assign memWrite   = (state == RMW_WR) | (state == WRITE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            memAdr     <= '0;
            writeData  <= '0;
            lane_q     <= '0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    lane_q     <= req_addr[1:0];
                    size_q     <= req_size;
                    sign_q     <= req_signed;
                    wdata_q    <= req_wdata;
                    resp_rdata <= '0;
                    resp_err   <= req_err;
                    if (req_err) begin
                        state <= RESP;
                    end else begin
                        memAdr <= {req_addr[31:2], 2'b00};
                        if (!req_write) begin
                            state <= READ;
                        end else if (req_size == SZ_WORD) begin
                            writeData <= req_wdata;
                            state     <= WRITE;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                READ: begin
                    resp_rdata <= rdata;
                    state      <= RESP;
                end
                RMW_RD: begin
                    writeData <= merged;
                    state     <= RMW_WR;
                end
                RMW_WR:  state <= RESP;
                WRITE:   state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a word-organised memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] memAdr;
    logic        memRead;
    logic        memWrite;
    logic [31:0] writeData;
    logic [31:0] readData;

    logic [31:0] mem [0:127];
    int checks = 0;
    int failures = 0;
    int both_cnt = 0;

    // Per-transaction observations
    int lat, rd_cyc, wr_cyc, wr_first, ready_hi;
    logic [31:0] r_rdata, r_err, wr_data, wr_adr;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .memAdr     (memAdr),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .writeData  (writeData),
        .readData   (readData)
    );

    always #5 clk = ~clk;

    assign readData = mem[memAdr[8:2]];

    always @(negedge clk) begin
        if (memWrite) mem[memAdr[8:2]] <= writeData;
        if (memRead && memWrite) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic xact(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = 32'h5A5A5A5A; req_addr = 32'hFFFF_FFFF;
        lat = 0; rd_cyc = 0; wr_cyc = 0; wr_first = 0; ready_hi = 0;
        r_rdata = 32'hX; r_err = 32'hX; wr_data = 32'h0; wr_adr = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            if (req_ready) ready_hi++;
            if (memRead) rd_cyc++;
            if (memWrite) begin
                wr_cyc++;
                if (wr_first == 0) wr_first = k;
                wr_data = writeData;
                wr_adr  = memAdr;
            end
            if (resp_valid) begin
                lat = k; r_rdata = resp_rdata; r_err = {31'd0, resp_err};
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", resp_err, 0);
        check("rst_memAdr", memAdr, 0);
        check("rst_strobes", {memRead, memWrite}, 0);
        check("rst_writeData", writeData, 0);
        rst = 1'b0;

        // Word store then word load
        xact(1, 2'b10, 0, 32'h400, 32'hDEADBEEF);
        check("ws_lat", lat, 2);
        check("ws_wr_first", wr_first, 1);
        check("ws_wr_cnt", wr_cyc, 1);
        check("ws_adr", wr_adr, 32'h400);
        check("ws_data", wr_data, 32'hDEADBEEF);
        check("ws_err", r_err, 0);
        check("ws_rdata", r_rdata, 0);
        check("ws_ready_low", ready_hi, 0);
        xact(0, 2'b10, 1, 32'h400, 0);
        check("wl_lat", lat, 2);
        check("wl_rd_cnt", rd_cyc, 1);
        check("wl_rdata", r_rdata, 32'hDEADBEEF);

        // Byte store read-modify-write
        xact(1, 2'b10, 0, 32'h404, 32'h11223344);
        xact(1, 2'b00, 0, 32'h405, 32'h000000AB);
        check("bs_lat", lat, 3);
        check("bs_rd_cnt", rd_cyc, 1);
        check("bs_wr_first", wr_first, 2);
        check("bs_wr_cnt", wr_cyc, 1);
        check("bs_data", wr_data, 32'h1122AB44);
        check("bs_adr", wr_adr, 32'h404);
        check("bs_mem", mem[1], 32'h1122AB44);

        // Lane extraction with sign/zero extension
        xact(1, 2'b10, 0, 32'h408, 32'h8001AB44);
        xact(0, 2'b00, 1, 32'h409, 0);
        check("lb_s", r_rdata, 32'hFFFFFFAB);
        xact(0, 2'b00, 0, 32'h409, 0);
        check("lb_u", r_rdata, 32'h000000AB);
        xact(0, 2'b01, 1, 32'h40A, 0);
        check("lh_s", r_rdata, 32'hFFFF8001);
        xact(0, 2'b01, 0, 32'h40A, 0);
        check("lh_u", r_rdata, 32'h00008001);
        xact(0, 2'b00, 1, 32'h408, 0);
        check("lb0_s", r_rdata, 32'h00000044);
        xact(1, 2'b01, 0, 32'h40A, 32'hFFFF5566);
        check("hs_lat", lat, 3);
        check("hs_data", wr_data, 32'h5566AB44);
        xact(0, 2'b10, 1, 32'h408, 0);
        check("hs_readback", r_rdata, 32'h5566AB44);

        // Misaligned requests
        xact(0, 2'b01, 1, 32'h401, 0);
        check("mis_h_lat", lat, 1);
        check("mis_h_err", r_err, 1);
        check("mis_h_rdata", r_rdata, 0);
        check("mis_h_strobes", rd_cyc + wr_cyc, 0);
        xact(1, 2'b10, 0, 32'h402, 32'h12345678);
        check("mis_w_lat", lat, 1);
        check("mis_w_err", r_err, 1);
        check("mis_w_strobes", rd_cyc + wr_cyc, 0);
        xact(0, 2'b11, 0, 32'h400, 0);
        check("mis_sz3_err", r_err, 1);

        // Out-of-range store
        xact(1, 2'b10, 0, 32'h500, 32'hA5A5A5A5);
`ifdef LSU_RANGE_CHECK_EN
        check("oor_lat", lat, 1);
        check("oor_err", r_err, 1);
        check("oor_wr_cnt", wr_cyc, 0);
`else
        check("oor_lat", lat, 2);
        check("oor_err", r_err, 0);
        check("oor_wr_cnt", wr_cyc, 1);
        check("oor_adr", wr_adr, 32'h500);
`endif

        // Reset during RMW_RD aborts the byte store
        xact(1, 2'b10, 0, 32'h40C, 32'hCAFEF00D);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h40D; req_wdata = 32'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_in_rmw_rd", memRead, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ready", req_ready, 1);
        check("abort_resp", resp_valid, 0);
        check("abort_wr", memWrite, 0);
        begin
            int stray = 0;
            for (int k = 0; k < 4; k++) begin
                if (resp_valid || memWrite) stray++;
                @(posedge clk); #1;
            end
            check("abort_stray", stray, 0);
        end
        check("abort_mem", mem[3], 32'hCAFEF00D);
        xact(0, 2'b10, 0, 32'h40C, 0);
        check("abort_readback", r_rdata, 32'hCAFEF00D);

        check("no_both_strobes", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface: accepts one load or store per transaction from the pipeline's memory stage and drives the word-organised data memory through `memAdr`/`memRead`/`memWrite`/`writeData`/`readData`. Converts byte, halfword and word requests into word accesses, using read-modify-write for sub-word stores and lane extraction with sign or zero extension for loads. Flags misaligned requests and, optionally, out-of-range requests without touching memory. Sits between the execute/memory pipeline stage and the data memory.

## Interface
- `DATA_BASE`, 1024: byte address of data-memory word 0.
- `DATA_BYTES`, 256: size of the data region in bytes.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle, request accepted when `req_valid & req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as misaligned.
- `req_signed` in 1: sign-extend load result.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: load result, 0 for stores and errors.
- `resp_err` out 1: valid with `resp_valid`; misaligned or out of range.
- `memAdr` out 32: word-aligned byte address, `{addr[31:2],2'b00}`.
- `memRead` out 1: read strobe; `readData` is sampled while it is high.
- `memWrite` out 1: write strobe; memory commits on the falling edge.
- `writeData` out 32: full word to write.
- `readData` in 32: word returned by memory.

## Operation
- States: IDLE, READ, RMW_RD, RMW_WR, WRITE, RESP.
- IDLE: `req_ready`=1. On accept, latch addr, size, signed and wdata.
  - Misaligned request (half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11): go to RESP with err.
  - Load: go to READ.
  - Word store: go to WRITE.
  - Byte or half store: go to RMW_RD.
- READ: `memRead`=1. Capture `readData` at the closing rising edge, extract the lane, then go to RESP.
- RMW_RD: `memRead`=1. Capture `readData` into the merge register, then go to RMW_WR.
- RMW_WR: `memWrite`=1. `writeData` is the merged word, then go to RESP.
- WRITE: `memWrite`=1. `writeData` = `req_wdata`, then go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then go to IDLE. There is no response backpressure.
- Lanes are little-endian.
  - Byte lane = `addr[1:0]`; half lane = `addr[1]`.
  - Byte store replaces bits `[8k+7:8k]` with `wdata[7:0]`.
  - Half store replaces bits `[16h+15:16h]` with `wdata[15:0]`.
  - Loads shift the selected lane to bit 0, then zero- or sign-extend per `req_signed`. Word loads ignore `req_signed`.
- `memRead` and `memWrite` are never both high. Each is decoded solely from the registered state.
- `memAdr` and `writeData` hold their last values outside access states. Both strobes are 0 in IDLE and RESP.

## Timing
- Accept at cycle T. `resp_valid` rises at:
  - T+1 for an error;
  - T+2 for a load or word store;
  - T+3 for a sub-word store.
- `req_ready` is low from T+1 until the RESP cycle ends, so issue rate is at most one request per 2–4 cycles.
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `memAdr`=0, `memRead`=0, `memWrite`=0, `writeData`=0.
- Reset has priority over every transition.
  - `rst` sampled high in any state returns the block to IDLE at that edge.
  - No response is issued for an aborted transaction.
  - A `memWrite` already high during the cycle in which `rst` is sampled may still commit at that cycle's falling edge; no later write occurs.
- `req_*` inputs are sampled only at accept; later changes are ignored.

## Configuration
- `LSU_RANGE_CHECK_EN` defined: a request with `addr < DATA_BASE` or `addr + bytes > DATA_BASE + DATA_BYTES` goes to RESP with `resp_err`=1. It causes no memory strobe.
- `LSU_RANGE_CHECK_EN` undefined: no range check, and the address passes through unchanged. Only misalignment raises `resp_err`.

## Structure
- Package `lsu_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - state enum;
  - default `DATA_BASE`/`DATA_BYTES` constants.
- Sub-module `lsu_lane_align`: purely combinational. Handles store merge (old word, wdata, size, lane → new word) and load extract (word, size, lane, signed → result). It is instantiated once.

## Test plan
- Word store 0xDEADBEEF @0x400, then word load @0x400 → `memWrite` high only at T+1 with `memAdr`=0x400; load `resp_rdata`=0xDEADBEEF at T+2.
- Word 0x11223344 @0x404, then byte store 0xAB @0x405 → RMW_RD at T+1, one-cycle `memWrite` at T+2 with `writeData`=0x1122AB44, `resp_valid` at T+3.
- Word 0x8001AB44 @0x408:
  - signed byte load @0x409 → 0xFFFFFFAB;
  - unsigned byte load @0x409 → 0x000000AB;
  - signed half load @0x40A → 0xFFFF8001.
- Half load @0x401 and word store @0x402 → `resp_err`=1, `resp_rdata`=0 at T+1, no strobe ever asserted.
- Word store @0x500 → with `LSU_RANGE_CHECK_EN`: err, no `memWrite`; without it: `memWrite` with `memAdr`=0x500.
- `rst` high during RMW_RD of a byte store → IDLE next cycle, `req_ready`=1, no `memWrite`, no `resp_valid`, target word unchanged.
